// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO and programmable baud divisor.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hD000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  rd_data,
  output logic        sel,
  output logic        txd
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [15:0] off, div, bc, pm1;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh, status;
  logic overflow, empty, full, busy, bit_end, pop, wr_data, push;
  assign off     = AB - BASE_ADDR;
  assign sel     = off < 16'd4;
  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(FIFO_DEPTH);
  assign busy    = state != IDLE;
  assign pm1     = div == '0 ? 16'd1 : div;
  assign bit_end = busy && bc == '0;
  assign pop     = !empty && (state == IDLE || (state == STOP && bit_end));
  assign wr_data = WE && sel && off[1:0] == 2'd0;
  assign push    = wr_data && !full;
  assign status  = {4'b0, overflow, empty, full, busy};
  assign rd_data = !sel ? 8'h00 : off[1:0] == 2'd1 ? status :
                   off[1:0] == 2'd2 ? div[7:0] : off[1:0] == 2'd3 ? div[15:8] : 8'h00;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div      <= DIV_RESET;
      overflow <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
    end else begin
      if (WE && sel && off[1:0] == 2'd1) overflow <= 1'b0;
      else if (wr_data && full) overflow <= 1'b1;
      if (WE && sel && off[1:0] == 2'd2) div[7:0] <= DO;
      if (WE && sel && off[1:0] == 2'd3) div[15:8] <= DO;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= DO;
  // txd is registered from the pre-edge state, so the line trails the FSM by one cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      bc      <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      txd     <= 1'b1;
    end else begin
      txd <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
      if (pop) begin
        sh    <= mem[rp];
        state <= START;
        bc    <= pm1;
      end else if (bit_end) begin
        bc    <= pm1;
        state <= state == START ? DATA : state == DATA ? (bit_cnt == 3'd7 ? STOP : DATA) : IDLE;
        if (state == DATA) begin
          sh      <= sh >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (busy) bc <= bc - 16'd1;
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;
  localparam logic [15:0] B = 16'hD000;
  logic clk = 1'b0, reset = 1'b0, WE = 1'b0, sel, txd;
  logic [15:0] AB = '0;
  logic [7:0]  DO = '0, rd_data;
  logic [7:0]  bytes [5];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mmio_uart_tx dut (.clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE),
                    .rd_data(rd_data), .sel(sel), .txd(txd));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(logic [15:0] a, logic [7:0] d);
    AB = a; DO = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; AB = 16'h0000;
  endtask
  task automatic check_reg(string tag, logic [15:0] a, logic [7:0] exp);
    AB = a;
    #1 check(tag, rd_data, exp);
    AB = 16'h0000;
  endtask
  function automatic logic exp_bit(logic [7:0] b, int sp, int p, int k);
    int j;
    if (k < sp) return 1'b0;
    j = (k - sp) / p;
    return j < 8 ? b[j] : 1'b1;
  endfunction
  // called at the negedge right after the DATA write edge; the pop happens on the next edge
  task automatic frame(logic [7:0] b, int p, int n);
    AB = B + 16'd1;
    @(negedge clk);
    check("busy_at_pop", rd_data[0], 1'b1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("txd_%02h_k%0d", b, k), txd, exp_bit(b, p, p, k));
      if (k < n - 1) check($sformatf("busy_%02h_k%0d", b, k), rd_data[0], 1'b1);
    end
    check("status_after_frame", rd_data, 8'h04);
    AB = 16'h0000;
  endtask
  initial begin
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (2) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check_reg("rst_status", B + 16'd1, 8'h04);
    check_reg("rst_div_lo", B + 16'd2, 8'h63);
    check_reg("rst_div_hi", B + 16'd3, 8'h03);
    @(negedge clk);
    reset = 1'b1;
    wr(B + 16'd2, 8'd3);
    wr(B + 16'd3, 8'd0);
    check_reg("div_lo_3", B + 16'd2, 8'h03);
    check_reg("div_hi_0", B + 16'd3, 8'h00);
    check_reg("data_reads_0", B, 8'h00);
    wr(B, 8'h55);
    frame(8'h55, 4, 40);
    wr(B + 16'd2, 8'd0);
    wr(B, 8'hA0);
    frame(8'hA0, 2, 20);
    wr(B + 16'd2, 8'd3);
    for (int i = 0; i < 5; i++) wr(B, bytes[i]);
    wr(B, 8'h66);
    check_reg("status_overflow", B + 16'd1, 8'h0B);
    wr(B + 16'd1, 8'hFF);
    check_reg("status_ovf_clear", B + 16'd1, 8'h03);
    for (int k = 4; k < 200; k++) begin
      if (k > 4) @(negedge clk);
      check($sformatf("b2b_k%0d", k), txd, exp_bit(bytes[k / 40], 4, 4, k % 40));
    end
    check_reg("status_after_b2b", B + 16'd1, 8'h04);
    wr(B, 8'h0F);
    @(negedge clk);
    @(negedge clk);
    check("divchg_k0", txd, exp_bit(8'h0F, 4, 2, 0));
    wr(B + 16'd2, 8'd1);
    check("divchg_k1", txd, exp_bit(8'h0F, 4, 2, 1));
    for (int k = 2; k < 22; k++) begin
      @(negedge clk);
      check($sformatf("divchg_k%0d", k), txd, exp_bit(8'h0F, 4, 2, k));
    end
    check_reg("divchg_idle", B + 16'd1, 8'h04);
    wr(B, 8'hAA);
    wr(B, 8'hBB);
    wr(B, 8'hCC);
    repeat (2) @(negedge clk);
    check("pre_rst_txd", txd, 1'b0);
    check_reg("pre_rst_status", B + 16'd1, 8'h01);
    reset = 1'b0;
    #1 check("midrst_txd", txd, 1'b1);
    check_reg("midrst_status", B + 16'd1, 8'h04);
    @(negedge clk);
    reset = 1'b1;
    check_reg("post_rst_div_lo", B + 16'd2, 8'h63);
    check_reg("post_rst_div_hi", B + 16'd3, 8'h03);
    repeat (12) @(negedge clk);
    check("post_rst_txd", txd, 1'b1);
    check_reg("post_rst_status", B + 16'd1, 8'h04);
    AB = B + 16'd4;
    #1 check("sel_b4", sel, 1'b0);
    check("rd_b4", rd_data, 8'h00);
    AB = B - 16'd1;
    #1 check("sel_bm1", sel, 1'b0);
    AB = B + 16'd3;
    #1 check("sel_b3", sel, 1'b1);
    @(negedge clk);
    wr(B + 16'd4, 8'h07);
    wr(B + 16'd6, 8'h12);
    check_reg("outside_div_lo", B + 16'd2, 8'h63);
    check_reg("outside_status", B + 16'd1, 8'h04);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, 16'hD000, first of four consecutive byte registers in the CPU address map.
REQ-002 Parameter FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..16.
REQ-003 Parameter DIV_RESET, 16'd867, reset baud divisor (115200 baud at 100 MHz).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 AB  input  16  CPU address bus.
REQ-007 DO  input  8  CPU write data.
REQ-008 WE  input  1  CPU write strobe; write qualified on rising clk edge.
REQ-009 rd_data  output  8  register read data, valid when sel=1.
REQ-010 sel  output  1  combinational: AB within BASE_ADDR..BASE_ADDR+3.
REQ-011 txd  output  1  serial line, 8N1, idle high.

Function
REQ-012 Register map: +0 DATA (W), +1 STATUS (R/W), +2 DIV_LO (R/W), +3 DIV_HI (R/W).
REQ-013 rd_data is combinational from AB with zero latency.
  - DATA reads 8'h00.
  - STATUS = {4'b0, overflow, fifo_empty, fifo_full, tx_busy}.
  - DIV_LO/DIV_HI return divisor bytes.
  - rd_data = 8'h00 when sel=0.
REQ-014 Write to DATA with FIFO not full pushes DO.
REQ-015 Write to DATA with FIFO full drops the byte and sets sticky overflow; FIFO contents unchanged.
REQ-016 Any write to STATUS clears overflow, regardless of DO.
REQ-017 Full/empty are judged on pre-edge occupancy. A same-cycle push and pop when full is a push to a full FIFO and is dropped with overflow set.
REQ-018 Bit period = max(divisor,1)+1 clk cycles; divisor 0 behaves as 1.
REQ-019 Divisor writes take effect at the next bit-period reload; a bit already in progress is not shortened or lengthened.
REQ-020 Transmit FSM states:
  - IDLE: txd=1.
  - START: txd=0, one bit period.
  - DATA: LSB first, 8 bit periods, 3-bit counter.
  - STOP: txd=1, one bit period.
REQ-021 IDLE with FIFO non-empty pops the head into the shift register and enters START on the same edge.
REQ-022 Line timing:
  - txd falls on the edge after the pop.
  - Frame occupies exactly 10 bit periods.
REQ-023 STOP end with FIFO non-empty pops the next byte and enters START directly, giving back-to-back frames with no idle gap. Otherwise the FSM returns to IDLE.
REQ-024 tx_busy=1 in START, DATA, STOP.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-026 txd is registered (glitch-free).
REQ-027 Writes with AB outside the window have no effect.

Reset
REQ-028 While reset=0, all of the following hold asynchronously:
  - txd=1, FSM=IDLE.
  - FIFO empty, pointers 0.
  - overflow=0, divisor=DIV_RESET, baud and bit counters 0.
REQ-029 Reset mid-frame aborts the frame immediately: txd=1 and queued bytes are discarded.
REQ-030 First write is accepted on the first rising edge after reset deasserts.

Verification
REQ-031 Divisor=3, write 8'h55 to DATA:
  - txd low 4 cycles, then 0x55 LSB first (1,0,1,0,1,0,1,0) at 4 cycles/bit, then high 4 cycles.
  - 40 cycles total; tx_busy high throughout.
REQ-032 Divisor=3, six back-to-back DATA writes:
  - Write 1 starts transmission; writes 2-5 fill the FIFO.
  - Write 6 sets overflow; STATUS reads 8'h0B.
  - Five frames follow with no idle gap between them.
REQ-033 Write STATUS during overflow -> overflow=0; STATUS reads 8'h03 while FIFO full and busy.
REQ-034 Divisor=0, write 8'hA0 -> each bit lasts 2 cycles; frame is 20 cycles.
REQ-035 Assert reset during the DATA state of a frame:
  - txd=1 and STATUS=8'h04 immediately, without a clock edge.
  - After release, divisor reads DIV_RESET (+2=8'h63, +3=8'h03).
REQ-036 Read AB=BASE_ADDR+4 -> sel=0, rd_data=8'h00.
REQ-037 Write DIV_LO during a frame -> current bit duration unchanged; new period applies from the next bit.
